// File: rtl/ann_load_if.sv
// Handshake and bus bundle between the ANN load controller and its environment:
// byte stream in, accelerator memory writes and start/done out, result channel out.
interface ann_load_if #(
  parameter int ADDR_W = 14
);
  logic              img_only;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              done;
  logic [3:0]        final_class;
  logic              res_valid;
  logic [3:0]        res_class;
  logic [1:0]        res_err;
  logic              res_ready;
  logic              busy;

  // Controller side
  modport master (
    input  img_only, s_valid, s_data, s_last, done, final_class, res_ready,
    output s_ready, wr_en, wr_addr, wr_data, start, res_valid, res_class, res_err, busy
  );

  // Stream source / accelerator / result consumer side
  modport slave (
    output img_only, s_valid, s_data, s_last, done, final_class, res_ready,
    input  s_ready, wr_en, wr_addr, wr_data, start, res_valid, res_class, res_err, busy
  );
endinterface

// File: rtl/ann_load_ctrl.sv
// Loads one frame from a byte stream into accelerator memory, fires a single start
// pulse, waits (with timeout) for done and presents the class / error code as a result.
module ann_load_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int IMG_BYTES = 784,
  parameter int TIMEOUT   = 1048575
) (
  input  logic       clk,
  input  logic       rst_n,
  ann_load_if.master bus
);
  localparam int                TW           = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IMG_IDX = ADDR_W'(IMG_BYTES - 1);
  localparam logic [ADDR_W-1:0] MAX_IDX      = '1;
  localparam logic [TW-1:0]     TIMER_LAST   = TW'(TIMEOUT - 1);
  localparam logic [1:0]        ERR_NONE     = 2'd0;
  localparam logic [1:0]        ERR_SHORT    = 2'd1;
  localparam logic [1:0]        ERR_OVF      = 2'd2;
  localparam logic [1:0]        ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT, RESULT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              mode_reg, mode_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic [3:0]        res_class_reg, res_class_next;
  logic [1:0]        res_err_reg, res_err_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;

  logic              accepting;
  logic              beat;
  logic [ADDR_W-1:0] beat_idx;
  logic              beat_mode;

  // s_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign accepting = rst_n && ((state_reg == IDLE) || (state_reg == LOAD));
  assign beat      = bus.s_valid && accepting;
  assign beat_idx  = (state_reg == IDLE) ? '0 : cnt_reg;
  assign beat_mode = (state_reg == IDLE) ? bus.img_only : mode_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mode_reg      <= 1'b0;
      timer_reg     <= '0;
      res_class_reg <= 4'h0;
      res_err_reg   <= ERR_NONE;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mode_reg      <= mode_next;
      timer_reg     <= timer_next;
      res_class_reg <= res_class_next;
      res_err_reg   <= res_err_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mode_next      = mode_reg;
    timer_next     = timer_reg;
    res_class_next = res_class_reg;
    res_err_next   = res_err_reg;
    wr_en_next     = beat;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;

    if (beat) begin
      wr_addr_next = beat_idx;
      wr_data_next = bus.s_data;
    end

    unique case (state_reg)
      IDLE, LOAD: begin
        if (beat) begin
          mode_next  = beat_mode;
          cnt_next   = beat_idx + ADDR_W'(1);
          state_next = LOAD;
          if (beat_mode) begin
            // Image-only frames end on byte count alone; s_last only matters if early.
            if (beat_idx == LAST_IMG_IDX) begin
              state_next = FLUSH;
            end else if (bus.s_last) begin
              state_next     = RESULT;
              res_err_next   = ERR_SHORT;
              res_class_next = 4'hF;
            end
          end else if (bus.s_last) begin
            if (beat_idx < LAST_IMG_IDX) begin
              state_next     = RESULT;
              res_err_next   = ERR_SHORT;
              res_class_next = 4'hF;
            end else begin
              state_next = FLUSH;
            end
          end else if (beat_idx == MAX_IDX) begin
            state_next     = RESULT;
            res_err_next   = ERR_OVF;
            res_class_next = 4'hF;
          end
        end
      end
      FLUSH: state_next = START;
      START: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.done) begin
          state_next     = RESULT;
          res_class_next = bus.final_class;
          res_err_next   = ERR_NONE;
        end else if (timer_reg == TIMER_LAST) begin
          // TIMEOUT consecutive WAIT cycles without done
          state_next     = RESULT;
          res_class_next = 4'hF;
          res_err_next   = ERR_TIMEOUT;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.s_ready   = accepting;
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;
  assign bus.start     = (state_reg == START);
  assign bus.res_valid = (state_reg == RESULT);
  assign bus.res_class = res_class_reg;
  assign bus.res_err   = res_err_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_ann_load_ctrl.sv
// Self-checking bench for ann_load_ctrl: a table of frame scenarios, random frames
// checked against a frame-level reference model, and a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_ann_load_ctrl;
  localparam int AW  = 11;
  localparam int IMG = 784;
  localparam int TO  = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ann_load_if #(.ADDR_W(AW)) bus();

  ann_load_ctrl #(.ADDR_W(AW), .IMG_BYTES(IMG), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed frame activity
  int         wq_addr[$];
  logic [7:0] wq_data[$];
  int         start_cnt, start_cyc, last_wr_cyc, overlap;
  int         got_res, act_err, act_cls, stable_bad, idle_bad, res_cyc;

  // Stimulus for the current frame
  logic [7:0] stim_data[$];
  bit         stim_last[$];

  typedef struct {
    bit io;  int nb;  int last_at;  int delay;  int cls;  int hold;  bit rv;
    int exp_wr;  int exp_st;  int exp_err;  int exp_cls;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Every wait goes through here so monitoring happens at each falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.wr_en) begin
      wq_addr.push_back(int'(bus.wr_addr));
      wq_data.push_back(bus.wr_data);
      last_wr_cyc = cyc;
    end
    if (bus.start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.wr_en && bus.start) overlap++;
  endtask

  function automatic int outputs_zero();
    return (bus.wr_en == 1'b0 && bus.wr_addr == '0 && bus.wr_data == 8'h00 &&
            bus.start == 1'b0 && bus.res_valid == 1'b0 && bus.res_class == 4'h0 &&
            bus.res_err == 2'd0 && bus.busy == 1'b0 && bus.s_ready == 1'b0) ? 1 : 0;
  endfunction

  task automatic build(input int nb, input int last_at);
    stim_data.delete();
    stim_last.delete();
    for (int i = 0; i < nb; i++) begin
      stim_data.push_back(8'($urandom_range(0, 255)));
      stim_last.push_back(i == last_at);
    end
  endtask

  // Frame-level reference: walk the offered beats and decide where and how the frame ends.
  function automatic void model(input bit io, input int delay, input int cls,
                                output int e_wr, output int e_st, output int e_err,
                                output int e_cls);
    e_wr = 0; e_st = 0; e_err = 0;
    for (int i = 0; i < stim_data.size(); i++) begin
      e_wr = i + 1;
      if (io) begin
        if (i == IMG - 1) begin e_st = 1; break; end
        if (stim_last[i]) begin e_err = 1; break; end
      end else begin
        if (stim_last[i]) begin
          if (i >= IMG - 1) e_st = 1; else e_err = 1;
          break;
        end
        if (i == (1 << AW) - 1) begin e_err = 2; break; end
      end
    end
    if (e_st == 1) e_err = (delay >= 1 && delay <= TO) ? 0 : 3;
    e_cls = (e_st == 1 && e_err == 0) ? cls : 15;
  endfunction

  task automatic run_frame(input bit io, input int delay, input int cls, input int hold,
                           input bit rv);
    int j = 0;
    int t = 0;
    wq_addr.delete(); wq_data.delete();
    start_cnt = 0; start_cyc = 0; last_wr_cyc = 0; overlap = 0;
    got_res = 0; act_err = -1; act_cls = -1; stable_bad = 0; idle_bad = 0; res_cyc = 0;
    // Stream phase; done wiggles randomly here and must be ignored
    forever begin
      tick();
      t++;
      if (j >= stim_data.size() || (j > 0 && !bus.s_ready) || t > 20000) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.done    = 1'b0;
        break;
      end
      bus.img_only    = (j == 0) ? io : 1'($urandom_range(0, 1));
      bus.s_valid     = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data      = stim_data[j];
      bus.s_last      = stim_last[j];
      bus.done        = 1'($urandom_range(0, 1));
      bus.final_class = 4'($urandom_range(0, 15));
      #1;
      if (bus.s_valid && bus.s_ready) j++;
    end
    // Accelerator and result phase
    t = 0;
    while (t < 3000) begin
      if (start_cnt > 0 && delay > 0 && cyc == start_cyc + delay) begin
        bus.done        = 1'b1;
        bus.final_class = 4'(cls);
      end
      if (bus.res_valid) begin
        got_res = 1;
        break;
      end
      tick();
      t++;
    end
    if (got_res == 1) begin
      res_cyc = cyc;
      act_err = int'(bus.res_err);
      act_cls = int'(bus.res_class);
      for (int h = 0; h < hold; h++) begin
        tick();
        bus.final_class = 4'($urandom_range(0, 15));
        if (!bus.res_valid || int'(bus.res_err) != act_err || int'(bus.res_class) != act_cls)
          stable_bad++;
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      bus.done      = 1'b0;
      if (bus.busy || bus.res_valid) idle_bad++;
    end else begin
      bus.done = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int delay, input int e_wr, input int e_st,
                             input int e_err, input int e_cls);
    int data_bad = 0;
    for (int i = 0; i < wq_addr.size(); i++) begin
      if (wq_addr[i] != i) data_bad++;
      else if (i >= stim_data.size()) data_bad++;
      else if (wq_data[i] != stim_data[i]) data_bad++;
    end
    $display("frame %s: writes=%0d starts=%0d res_err=%0d res_class=%0d", tag,
             wq_addr.size(), start_cnt, act_err, act_cls);
    chk({tag, "_result_seen"}, got_res, 1);
    chk({tag, "_writes"}, wq_addr.size(), e_wr);
    chk({tag, "_addr_data_errs"}, data_bad, 0);
    chk({tag, "_starts"}, start_cnt, e_st);
    chk({tag, "_res_err"}, act_err, e_err);
    chk({tag, "_res_class"}, act_cls, e_cls);
    chk({tag, "_wr_start_overlap"}, overlap, 0);
    chk({tag, "_result_unstable"}, stable_bad, 0);
    chk({tag, "_not_idle_after_accept"}, idle_bad, 0);
    if (e_st == 1) begin
      chk({tag, "_start_after_last_wr"}, start_cyc - last_wr_cyc, 1);
      chk({tag, "_res_latency"}, res_cyc - start_cyc, (e_err == 0) ? delay + 1 : TO + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_wr, e_st, e_err, e_cls, bad, j, t;
    bit io;
    int pick, last_at, delay, cls, hold;

    //            io  nb    last  dly  cls hold rv   wr    st err cls
    vecs[0]  = '{1, 784,  -1,   50,  6,  0,  0,  784,  1, 0, 6};
    vecs[1]  = '{0, 1784, 1783, 10,  9,  0,  0,  1784, 1, 0, 9};
    vecs[2]  = '{1, 784,  99,   5,   3,  2,  0,  100,  0, 1, 15};
    vecs[3]  = '{1, 784,  -1,   -1,  5,  1,  0,  784,  1, 3, 15};
    vecs[4]  = '{0, 784,  500,  5,   1,  0,  0,  501,  0, 1, 15};
    vecs[5]  = '{0, 2100, -1,   5,   1,  0,  0,  2048, 0, 2, 15};
    vecs[6]  = '{1, 800,  783,  3,   2,  20, 1,  784,  1, 0, 2};
    vecs[7]  = '{0, 784,  783,  100, 11, 0,  0,  784,  1, 0, 11};
    vecs[8]  = '{1, 784,  -1,   101, 7,  3,  0,  784,  1, 3, 15};
    vecs[9]  = '{0, 1000, 782,  5,   4,  0,  0,  783,  0, 1, 15};
    vecs[10] = '{1, 784,  0,    5,   8,  0,  0,  1,    0, 1, 15};
    vecs[11] = '{0, 2048, 2047, 8,   13, 0,  0,  2048, 1, 0, 13};

    bus.img_only = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    bus.done = 1'b0; bus.final_class = 4'h0; bus.res_ready = 1'b0;

    repeat (2) tick();
    chk("reset_state", outputs_zero(), 1);
    rst_n = 1'b1;
    #1;
    chk("ready_after_first_reset", int'(bus.s_ready), 1);

    for (int v = 0; v < 12; v++) begin
      build(vecs[v].nb, vecs[v].last_at);
      run_frame(vecs[v].io, vecs[v].delay, vecs[v].cls, vecs[v].hold, vecs[v].rv);
      check_frame($sformatf("vec%0d", v), vecs[v].delay, vecs[v].exp_wr, vecs[v].exp_st,
                  vecs[v].exp_err, vecs[v].exp_cls);
    end

    for (int r = 0; r < 4; r++) begin
      io   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 2);
      if (io) begin
        last_at = (pick == 0) ? $urandom_range(0, 782) : ((pick == 1) ? 783 : -1);
        build(800, last_at);
      end else if (pick == 2) begin
        build(2060, -1);
      end else begin
        last_at = (pick == 0) ? $urandom_range(0, 782) : $urandom_range(783, 1500);
        build(last_at + 5, last_at);
      end
      delay = $urandom_range(1, 120);
      cls   = $urandom_range(0, 14);
      hold  = $urandom_range(0, 25);
      model(io, delay, cls, e_wr, e_st, e_err, e_cls);
      run_frame(io, delay, cls, hold, 1'b1);
      check_frame($sformatf("rnd%0d", r), delay, e_wr, e_st, e_err, e_cls);
    end

    // Reset after 300 beats, then a clean frame
    build(IMG, -1);
    bus.img_only = 1'b1;
    j = 0; t = 0;
    while (j < 300 && t < 1000) begin
      tick();
      bus.s_valid = 1'b1;
      bus.s_data  = stim_data[j];
      bus.s_last  = 1'b0;
      #1;
      if (bus.s_ready) j++;
      t++;
    end
    tick();
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_zero", outputs_zero(), 1);
    bad = 0;
    repeat (3) begin
      tick();
      if (outputs_zero() == 0) bad++;
    end
    chk("reset_hold_zero", bad, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_midframe_reset", int'(bus.s_ready), 1);
    build(IMG, -1);
    run_frame(1'b1, 20, 4, 0, 1'b0);
    check_frame("after_reset", 20, 784, 1, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ann_load_ctrl.md
ANN_LOAD_CTRL -- requirements
Module: ann_load_ctrl

Interface
REQ-001 Parameter ADDR_W, default 14, write-address width of the accelerator memory port.
REQ-002 Parameter IMG_BYTES, default 784, image bytes per frame, written to addresses 0..IMG_BYTES-1.
REQ-003 Parameter TIMEOUT, default 1048575, max cycles from start pulse to done before abort.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 img_only  in  1  frame mode, sampled on first accepted beat; 1 = image only, 0 = image plus weights.
REQ-007 s_valid  in  1  byte-stream beat valid.
REQ-008 s_data  in  8  byte-stream data.
REQ-009 s_last  in  1  marks final beat of a frame.
REQ-010 s_ready  out  1  byte-stream accept.
REQ-011 wr_en  out  1  accelerator memory write strobe.
REQ-012 wr_addr  out  ADDR_W  accelerator memory write address.
REQ-013 wr_data  out  8  accelerator memory write data.
REQ-014 start  out  1  one-cycle inference start pulse.
REQ-015 done  in  1  accelerator inference complete, level.
REQ-016 final_class  in  4  accelerator predicted class, valid while done=1.
REQ-017 res_valid  out  1  result available.
REQ-018 res_class  out  4  captured class; 4'hF on any error.
REQ-019 res_err  out  2  error code, valid with res_valid: 0 none, 1 short frame, 2 overflow, 3 timeout.
REQ-020 res_ready  in  1  result consumer accept.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 States IDLE, LOAD, FLUSH, START, WAIT, RESULT; beat = s_valid&s_ready.
REQ-023 s_ready high only in IDLE and LOAD; low in all other states.
REQ-024 IDLE: beat -> latch img_only, write byte at address 0, byte count=1, go LOAD.
REQ-025 Each beat produces exactly one write the next cycle: wr_en=1, wr_addr=byte index in frame, wr_data=beat data; wr_en=0 otherwise.
REQ-026 Addresses increase by 1 per beat from 0, no gaps, no repeats within a frame.
REQ-027 img_only=1: beat with index IMG_BYTES-1 is last; s_last on it is ignored; go FLUSH.
REQ-028 img_only=1, s_last on a beat with index < IMG_BYTES-1: byte is written, no start issued, res_err=1, go RESULT.
REQ-029 img_only=0: beat with s_last is last, go FLUSH; if s_last arrives with index < IMG_BYTES-1, res_err=1, go RESULT.
REQ-030 img_only=0, beat at index 2^ADDR_W-1 without s_last: written, res_err=2, go RESULT; stream not drained.
REQ-031 FLUSH: one cycle so final wr_en completes; go START.
REQ-032 START: start=1 for exactly one cycle, exactly one cycle after the final wr_en; wr_en and start never high together; clear timeout counter; go WAIT.
REQ-033 WAIT: first cycle done=1 -> res_class=final_class, res_err=0, go RESULT.
REQ-034 WAIT: counter reaches TIMEOUT with done=0 -> res_class=4'hF, res_err=3, go RESULT.
REQ-035 RESULT: res_valid=1; res_class/res_err stable until res_valid&res_ready; then IDLE next cycle.
REQ-036 done asserted outside WAIT is ignored.
REQ-037 Errors other than timeout set res_class=4'hF.

Reset
REQ-038 rst_n=0 forces IDLE immediately: wr_en=0, wr_addr=0, wr_data=0, start=0, res_valid=0, res_class=0, res_err=0, busy=0, s_ready=0 while asserted; counts cleared.
REQ-039 Reset mid-frame abandons the frame; next frame starts at address 0; s_ready=1 on first cycle after release.

Verification
REQ-040 img_only=1, 784 beats, done raised 50 cycles after start with final_class=6 -> writes 0..783 in order, one start pulse 1 cycle after write 783, res_class=6, res_err=0.
REQ-041 img_only=0, 784+1000 beats, s_last on beat 1783 -> last write addr 1783, one start pulse, result forwarded.
REQ-042 s_valid toggled randomly, res_ready held low 20 cycles -> no dropped/duplicated writes; res_valid and res_class held constant until accept.
REQ-043 img_only=1, s_last on beat 99 -> 100 writes, no start, res_err=1, res_class=4'hF.
REQ-044 TIMEOUT=100, done never raised -> res_err=3 at cycle 100 after start, res_class=4'hF, returns to IDLE after accept.
REQ-045 rst_n pulsed low after 300 beats, then full 784-beat frame -> all outputs at reset values during reset, second frame writes from address 0, single start.
